// File: rtl/iris_pkg.sv
// Shared types and constants for the Iris layer sequencer slice.
package iris_pkg;

    // Enabled cycles a neuron needs for one full pass (FLUSH/IDLE back to IDLE)
    localparam int NEURON_LATENCY = 7;

    // Width of the class index (three output classes)
    localparam int CLASS_W = 2;

    // Default fixed-point width of features and scores
    localparam int IRIS_DATA_WIDTH = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_EVAL   = 3'd3,
        ST_OUTPUT = 3'd4
    } seq_state_t;

    // Packed output-layer score vector, score 0 in the most significant slice
    typedef logic [3*IRIS_DATA_WIDTH-1:0] score_vec_t;

endpackage

// File: rtl/iris_argmax3.sv
// Combinational 3-input signed argmax; ties resolve to the lowest index.
// Score 0 occupies the most significant slice of the packed input.
module iris_argmax3
    import iris_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [3*DATA_WIDTH-1:0]  scores,
    output logic [CLASS_W-1:0]       idx,
    output logic signed [DATA_WIDTH-1:0] max_score
);

    logic signed [DATA_WIDTH-1:0] s0_s;
    logic signed [DATA_WIDTH-1:0] s1_s;
    logic signed [DATA_WIDTH-1:0] s2_s;

    assign s0_s = scores[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign s1_s = scores[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign s2_s = scores[DATA_WIDTH-1 -: DATA_WIDTH];

    // Strictly-greater comparisons so an equal later score never displaces an earlier one
    always_comb begin
        idx       = CLASS_W'(0);
        max_score = s0_s;
        if (s1_s > max_score) begin
            idx       = CLASS_W'(1);
            max_score = s1_s;
        end else begin
            idx       = idx;
            max_score = max_score;
        end
        if (s2_s > max_score) begin
            idx       = CLASS_W'(2);
            max_score = s2_s;
        end else begin
            idx       = idx;
            max_score = max_score;
        end
    end

endmodule

// File: rtl/iris_layer_sequencer.sv
// Iris network sequencer: warm-up pass after reset, sample capture, one-layer-
// at-a-time enable sequencing and argmax reduction of the output-layer scores.
module iris_layer_sequencer
    import iris_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_LAYERS     = 3,
    parameter int NEURON_LATENCY = iris_pkg::NEURON_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4*DATA_WIDTH-1:0]      x_in,
    output logic [4*DATA_WIDTH-1:0]      x_reg,
    output logic [NUM_LAYERS-1:0]        layer_en,
    output logic [NUM_LAYERS-1:0]        layer_run,
    input  logic [3*DATA_WIDTH-1:0]      y_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLASS_W-1:0]           class_id,
    output logic signed [DATA_WIDTH-1:0] class_score,
    output logic                         busy
);

    localparam int          LIDX_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [2:0]  CNT_LAST = 3'(NEURON_LATENCY - 1);
    localparam logic [LIDX_W-1:0] LIDX_LAST = LIDX_W'(NUM_LAYERS - 1);

    seq_state_t              state_r;
    seq_state_t              state_s;
    logic [2:0]              cnt_r;
    logic [2:0]              cnt_s;
    logic [LIDX_W-1:0]       lidx_r;
    logic [LIDX_W-1:0]       lidx_s;
    logic                    load_x_s;
    logic                    load_res_s;
    logic [CLASS_W-1:0]      arg_idx_s;
    logic signed [DATA_WIDTH-1:0] arg_score_s;

    iris_argmax3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_argmax (
        .scores    (y_out),
        .idx       (arg_idx_s),
        .max_score (arg_score_s)
    );

    // Control state, cycle counter and layer index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_WARMUP;
            cnt_r   <= 3'd0;
            lidx_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lidx_r  <= lidx_s;
        end
    end

    // Next-state logic: warm-up count, acceptance, per-layer pass counting, result handshake
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        lidx_s     = lidx_r;
        load_x_s   = 1'b0;
        load_res_s = 1'b0;
        case (state_r)
            ST_WARMUP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = 3'd0;
                    state_s = ST_READY;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_READY: begin
                if (in_valid) begin
                    load_x_s = 1'b1;
                    lidx_s   = '0;
                    cnt_s    = 3'd0;
                    state_s  = ST_RUN;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = 3'd0;
                    if (lidx_r < LIDX_LAST) begin
                        lidx_s = lidx_r + LIDX_W'(1);
                    end else begin
                        state_s = ST_EVAL;
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_EVAL: begin
                load_res_s = 1'b1;
                state_s    = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s = ST_WARMUP;
                cnt_s   = 3'd0;
                lidx_s  = '0;
            end
        endcase
    end

    // Output decode from registered state only; Run always mirrors En so IDLE never sees En without Run
    always_comb begin
        layer_en  = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_r)
            ST_WARMUP: begin
                layer_en = '1;
            end
            ST_READY: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_RUN: begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    layer_en[k] = (lidx_r == LIDX_W'(k));
                end
            end
            ST_EVAL: begin
                layer_en = '0;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
            end
            default: begin
                layer_en = '0;
            end
        endcase
        layer_run = layer_en;
    end

    // Feature register: loads only on input acceptance, stable for the whole pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
        end else if (load_x_s) begin
            x_reg <= x_in;
        end else begin
            x_reg <= x_reg;
        end
    end

    // Result registers: capture the argmax of the output-layer scores during EVAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            class_id    <= CLASS_W'(0);
            class_score <= '0;
        end else if (load_res_s) begin
            class_id    <= arg_idx_s;
            class_score <= arg_score_s;
        end else begin
            class_id    <= class_id;
            class_score <= class_score;
        end
    end

endmodule
